// File: rtl/lcd_req_arbiter.sv
// Round-robin arbiter granting the single SSD1963 bus engine to N requesters
// that handshake (4-phase req/ack) from foreign clock domains.
module lcd_req_arbiter #(
  parameter int unsigned N       = 4,
  parameter int unsigned IDW     = 2,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req_async,
  output logic [N-1:0]   ack,
  output logic           eng_start,
  output logic [IDW-1:0] eng_id,
  output logic           eng_busy,
  input  logic           eng_done,
  output logic           err,
  output logic [IDW-1:0] err_id
);

  localparam int unsigned CntW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StStart, StWait} state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   sync0_q, sync0_d;
  logic [N-1:0]   sync1_q, sync1_d;
  logic [N-1:0]   ack_q, ack_d;
  logic [IDW-1:0] last_q, last_d;
  logic [IDW-1:0] eng_id_q, eng_id_d;
  logic [IDW-1:0] err_id_q, err_id_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic           eng_start_q, eng_start_d;
  logic           err_q, err_d;

  logic [N-1:0]   elig;
  logic           found;
  logic [IDW-1:0] win_id;
  logic [IDW-1:0] rr_idx;

  // Round-robin search starting just after the last served requester.
  always_comb begin
    elig   = sync1_q & ~ack_q;
    found  = 1'b0;
    win_id = '0;
    rr_idx = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      rr_idx = IDW'((32'(last_q) + k) % N);
      if (!found && elig[rr_idx]) begin
        found  = 1'b1;
        win_id = rr_idx;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    sync0_d     = req_async;
    sync1_d     = sync0_q;
    // Acks drop as soon as the synchronized request is low; a set below overrides.
    ack_d       = ack_q & sync1_q;
    last_d      = last_q;
    eng_id_d    = eng_id_q;
    err_id_d    = err_id_q;
    cnt_d       = cnt_q;
    eng_start_d = 1'b0;
    err_d       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          eng_id_d    = win_id;
          eng_start_d = 1'b1;
          state_d     = StStart;
        end
      end
      StStart: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        cnt_d = cnt_q + CntW'(1);
        if (eng_done) begin
          ack_d[eng_id_q] = 1'b1;
          last_d          = eng_id_q;
          state_d         = StIdle;
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          ack_d[eng_id_q] = 1'b1;
          last_d          = eng_id_q;
          err_d           = 1'b1;
          err_id_d        = eng_id_q;
          state_d         = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      sync0_q     <= '0;
      sync1_q     <= '0;
      ack_q       <= '0;
      last_q      <= IDW'(N - 1);
      eng_id_q    <= '0;
      err_id_q    <= '0;
      cnt_q       <= '0;
      eng_start_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync0_q     <= sync0_d;
      sync1_q     <= sync1_d;
      ack_q       <= ack_d;
      last_q      <= last_d;
      eng_id_q    <= eng_id_d;
      err_id_q    <= err_id_d;
      cnt_q       <= cnt_d;
      eng_start_q <= eng_start_d;
      err_q       <= err_d;
    end
  end

  assign ack       = ack_q;
  assign eng_start = eng_start_q;
  assign eng_id    = eng_id_q;
  assign eng_busy  = (state_q != StIdle);
  assign err       = err_q;
  assign err_id    = err_id_q;

endmodule

// File: doc/lcd_req_arbiter.md
# lcd_req_arbiter

Round-robin arbiter that shares the single SSD1963 bus engine among N requesters living in foreign clock domains. Each requester uses a 4-phase level handshake (req/ack) across the domain boundary. The block synchronizes every request with its own two-stage flop chain, grants the engine to one requester at a time, and supervises each transaction with a timeout. It sits in the engine's clock domain between the per-domain producers and the bus write engine.

## Interface
- N, 4, number of requesters (2..8)
- IDW, 2, width of requester index, equals ceil(log2(N))
- TIMEOUT, 1024, maximum WAIT-state cycles before abort (>= 2)

- clk  in  1  engine-domain clock; the block's only clock
- rst  in  1  reset, synchronous and active-high
- req_async  in  N  level requests from foreign domains; unsynchronized
- ack  out  N  level acknowledges, registered, one per requester
- eng_start  out  1  one-cycle start pulse to the bus engine
- eng_id  out  IDW  index of the granted requester; valid while eng_busy
- eng_busy  out  1  high while a grant is in progress (state != IDLE)
- eng_done  in  1  engine completion pulse; sampled only in WAIT
- err  out  1  one-cycle pulse on transaction timeout
- err_id  out  IDW  requester index of the last timeout; held until the next timeout

## Operation
- Sync: per bit, sync0[i] <= req_async[i] and sync1[i] <= sync0[i]. Only sync1 is used internally.
- Eligible: elig[i] = sync1[i] & ~ack[i].
- Round-robin pointer `last` (IDW bits): search starts at last+1 mod N and wraps. The first eligible index wins.
- FSM states:
  - IDLE: if any elig, latch the winner into eng_id and go to START.
  - START: eng_start=1 for exactly this cycle; clear the timeout counter; go to WAIT.
  - WAIT: the counter increments each cycle.
    - If eng_done=1: set ack[eng_id], set last<=eng_id, go to IDLE.
    - Else if the counter reaches TIMEOUT-1: set ack[eng_id], set last<=eng_id, set err=1 and err_id<=eng_id, go to IDLE.
- eng_done and timeout in the same cycle: done wins, no err.
- eng_done outside WAIT is ignored.
- Ack clear: ack[i] <= 0 on any edge where sync1[i]=0, except that a set from WAIT at the same edge wins.
- Requester protocol: hold req until ack is high, then drop req, then wait for ack to go low before re-raising.
- A requester whose req is still high after its ack is not re-granted. It must drop req, see ack fall, and raise req again.
- If req drops mid-service, the transaction still completes. ack is set, then clears on the next edge.
- eng_id is stable from START through the end of WAIT. It holds its last value in IDLE.

## Timing
- Reset values (all synchronous):
  - sync0, sync1, ack = 0
  - state = IDLE
  - last = N-1, so index 0 has first priority after reset
  - eng_start = 0, eng_busy = 0, err = 0, err_id = 0, eng_id = 0, counter = 0
- Reset mid-transaction: abort at the reset edge and discard the grant. Requesters still holding req are re-served after 2 sync cycles.
- Request latency: with req_async sampled high at edge E0, sync1 is high after E1. IDLE moves to START at E2, so eng_start is high in the cycle after E2.
- Completion: eng_done sampled at edge Ed. ack is high and the FSM is in IDLE after Ed. The next grant's eng_start can appear one edge later.
- Timeout: err is high in the cycle after the edge where the TIMEOUT-th WAIT cycle ends.
- Ack release: req_async low sampled at Er gives ack low after Er+2.
- Throughput: at most one grant per 3 cycles (IDLE, START, WAIT with immediate done).

## Test plan
- Single request: req_async[0]=1 before E0 -> eng_start=1 and eng_id=0 for exactly one cycle after E2. eng_done after 5 WAIT cycles -> ack[0]=1 at the next edge. Drop req -> ack[0]=0 after Er+2.
- Four simultaneous requests after reset -> grants in order 0,1,2,3, each with one eng_start. Then reassert req 1 and 3 while 2 is pending -> order continues 2,3,1.
- Timeout: TIMEOUT=16, no eng_done -> after 16 WAIT cycles err=1 for one cycle, err_id=granted id, ack set, FSM returns to IDLE.
- eng_done on the final timeout cycle -> ack set, err stays 0.
- rst during WAIT with req 2 held -> eng_busy=0 and ack=0 after the reset edge. A stray eng_done is ignored. Requester 2 is re-granted 2 cycles after rst falls.
- Requester keeps req high after ack -> no second eng_start for it. Drop req, wait for ack=0, re-raise -> granted again.
